// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl_pkg
// Brief   : Shared types and constants for the pipeline hazard controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM_WAIT  = 2'd1,
        ST_CTRL_WAIT = 2'd2
    } state_e;

    // EX-stage operand mux selects
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
    localparam logic [1:0] FWD_MEM = 2'b01;  // MEM stage result
    localparam logic [1:0] FWD_EX  = 2'b10;  // EX/MEM ALU result

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// ============================================================================
// Module  : hazard_match
// Brief   : Compares one ID source register against the EX and MEM producers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_match #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic              src_en_i,
    input  logic              ex_wr_i,
    input  logic [REG_AW-1:0] ex_dst_i,
    input  logic              mem_wr_i,
    input  logic [REG_AW-1:0] mem_dst_i,
    output logic              ex_match_o,
    output logic              mem_match_o
);

    // Register $0 is hard-wired to zero, so writes to it never create a dependency
    always_comb begin
        ex_match_o  = src_en_i && ex_wr_i  && (ex_dst_i  == src_i) && (ex_dst_i  != '0);
        mem_match_o = src_en_i && mem_wr_i && (mem_dst_i == src_i) && (mem_dst_i != '0);
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Stall/flush/forwarding controller for a 5-stage MIPS pipeline with
//           memory-wait handling, control-transfer watchdog and perf counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int FWD_EN       = 1,
    parameter int CTRL_TIMEOUT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic              id_is_ctrl_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_dst_i,
    input  logic              mem_reg_write_i,
    input  logic [REG_AW-1:0] mem_dst_i,
    input  logic              ctrl_resolve_i,
    input  logic              mem_busy_i,
    output logic              pc_stall_o,
    output logic              ifid_stall_o,
    output logic              ifid_flush_o,
    output logic              idex_flush_o,
    output logic              exmem_stall_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              ctrl_timeout_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int WD_W = $clog2(CTRL_TIMEOUT + 1);

    state_e            state_q, state_d, ret_q, ret_d, cur_st;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic rs_ex, rs_mem, rt_ex, rt_mem;
    logic data_hazard;
    logic [1:0] fwd_a, fwd_b;
    logic pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall;

    hazard_match #(.REG_AW(REG_AW)) u_match_rs (
        .src_i      (id_rs_i),
        .src_en_i   (1'b1),
        .ex_wr_i    (ex_reg_write_i),
        .ex_dst_i   (ex_dst_i),
        .mem_wr_i   (mem_reg_write_i),
        .mem_dst_i  (mem_dst_i),
        .ex_match_o (rs_ex),
        .mem_match_o(rs_mem)
    );

    hazard_match #(.REG_AW(REG_AW)) u_match_rt (
        .src_i      (id_rt_i),
        .src_en_i   (id_uses_rt_i),
        .ex_wr_i    (ex_reg_write_i),
        .ex_dst_i   (ex_dst_i),
        .mem_wr_i   (mem_reg_write_i),
        .mem_dst_i  (mem_dst_i),
        .ex_match_o (rt_ex),
        .mem_match_o(rt_mem)
    );

    // Hazard classification and forwarding selects (EX producer wins over MEM)
    always_comb begin
        data_hazard = 1'b0;
        fwd_a       = FWD_RF;
        fwd_b       = FWD_RF;
        if (FWD_EN != 0) begin
            data_hazard = ex_mem_read_i && (rs_ex || rt_ex);
            if (rs_ex)       fwd_a = FWD_EX;
            else if (rs_mem) fwd_a = FWD_MEM;
            if (rt_ex)       fwd_b = FWD_EX;
            else if (rt_mem) fwd_b = FWD_MEM;
        end else begin
            data_hazard = rs_ex || rt_ex || rs_mem || rt_mem;
        end
    end

    // Next-state and Mealy stall/flush outputs
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        wdog_d      = wdog_q;
        timeout_d   = timeout_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        // Leaving MEM_WAIT acts as the remembered state in the same cycle
        cur_st      = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

        if (mem_busy_i) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            exmem_stall = 1'b1;
            state_d     = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) ret_d = state_q;
        end else if (cur_st == ST_CTRL_WAIT) begin
            wdog_d = wdog_q - WD_W'(1);
            if (ctrl_resolve_i) begin
                state_d = ST_RUN;
            end else begin
                pc_stall   = 1'b1;
                ifid_flush = 1'b1;
                if (wdog_q == WD_W'(1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    state_d   = ST_CTRL_WAIT;
                end
            end
        end else begin
            state_d = ST_RUN;
            if (data_hazard) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end else if (id_is_ctrl_i) begin
                pc_stall   = 1'b1;
                ifid_flush = 1'b1;
                state_d    = ST_CTRL_WAIT;
                wdog_d     = WD_W'(CTRL_TIMEOUT);
            end
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if ((ifid_flush || idex_flush) && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // State, watchdog, sticky flag and counter registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_RUN;
            ret_q       <= ST_RUN;
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            wdog_q      <= wdog_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Combinational outputs are forced quiet while reset is held
    always_comb begin
        pc_stall_o    = pc_stall    && !reset_i;
        ifid_stall_o  = ifid_stall  && !reset_i;
        ifid_flush_o  = ifid_flush  && !reset_i;
        idex_flush_o  = idex_flush  && !reset_i;
        exmem_stall_o = exmem_stall && !reset_i;
        fwd_a_o       = reset_i ? FWD_RF : fwd_a;
        fwd_b_o       = reset_i ? FWD_RF : fwd_b;
    end

    assign ctrl_timeout_o = timeout_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

endmodule

`default_nettype wire
